// File: rtl/rgb666to111_dither.sv
// rgb666to111_dither: RGB666 -> RGB111 quantiser for the overlay path.
// 4x4 ordered dither or fixed threshold, fixed 2-cycle pipeline.
module rgb666to111_dither #(
  parameter int unsigned THRESHOLD          = 32,
  parameter bit          FRAME_PHASE_TOGGLE = 1'b0
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [17:0] rgb_666,
  input  logic        pix_valid,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic        dither_en,
  output logic [2:0]  rgb_111,
  output logic        pix_valid_out,
  output logic        line_start_out,
  output logic        frame_start_out
);

  localparam logic [6:0] TH = 7'(THRESHOLD);

  function automatic logic [3:0] bayer(
    input logic [1:0] y,
    input logic [1:0] x
  );
    logic [3:0] m;
    m = 4'd0;
    unique case ({y, x})
      4'h0: m = 4'd0;
      4'h1: m = 4'd8;
      4'h2: m = 4'd2;
      4'h3: m = 4'd10;
      4'h4: m = 4'd12;
      4'h5: m = 4'd4;
      4'h6: m = 4'd14;
      4'h7: m = 4'd6;
      4'h8: m = 4'd3;
      4'h9: m = 4'd11;
      4'ha: m = 4'd1;
      4'hb: m = 4'd9;
      4'hc: m = 4'd15;
      4'hd: m = 4'd7;
      4'he: m = 4'd13;
      4'hf: m = 4'd5;
    endcase
    return m;
  endfunction

  logic [1:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  xu, yu, xe;
  logic        tog_q, tog_d, seen_q, seen_d;
  logic        teff;

  logic [17:0] rgb_s1_q;
  logic        v_s1_q, ls_s1_q, fs_s1_q, de_s1_q;
  logic [3:0]  b_s1_q;

  logic [5:0]  r, g, b, t;
  logic [2:0]  bits_d;
  logic [2:0]  rgb_q;
  logic        v_q, ls_q, fs_q;

  // Phase used by the current pixel and the phase state after it.
  // A frame counts as frame 1 for the temporal flip; later frames alternate.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    tog_d  = tog_q;
    seen_d = seen_q;
    xu     = x_q;
    yu     = y_q;
    if (pix_valid) begin
      if (frame_start) begin
        xu     = 2'd0;
        yu     = 2'd0;
        x_d    = 2'd1;
        y_d    = 2'd0;
        tog_d  = ~tog_q;
        seen_d = 1'b1;
      end else if (line_start) begin
        xu  = 2'd0;
        yu  = y_q + 2'd1;
        x_d = 2'd1;
        y_d = y_q + 2'd1;
      end else begin
        x_d = x_q + 2'd1;
      end
    end
    teff = FRAME_PHASE_TOGGLE & seen_d & ~tog_d;
    xe   = xu ^ {teff, 1'b0};
  end

  // Phase counters advance only on valid pixels.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      x_q    <= '0;
      y_q    <= '0;
      tog_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      tog_q  <= tog_d;
      seen_q <= seen_d;
    end
  end

  // Stage 1: capture pixel, qualified flags and the Bayer value.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rgb_s1_q <= '0;
      v_s1_q   <= 1'b0;
      ls_s1_q  <= 1'b0;
      fs_s1_q  <= 1'b0;
      de_s1_q  <= 1'b0;
      b_s1_q   <= '0;
    end else begin
      rgb_s1_q <= rgb_666;
      v_s1_q   <= pix_valid;
      ls_s1_q  <= pix_valid & line_start;
      fs_s1_q  <= pix_valid & frame_start;
      de_s1_q  <= dither_en;
      b_s1_q   <= bayer(yu, xe);
    end
  end

  assign r = rgb_s1_q[17:12];
  assign g = rgb_s1_q[11:6];
  assign b = rgb_s1_q[5:0];

  // Per-channel compare; gaps produce zero.
  always_comb begin
    t      = {b_s1_q, 2'b10};
    bits_d = '0;
    if (v_s1_q) begin
      if (de_s1_q) begin
        bits_d = {r >= t, g >= t, b >= t};
      end else begin
        bits_d = {{1'b0, r} >= TH, {1'b0, g} >= TH, {1'b0, b} >= TH};
      end
    end
  end

  // Stage 2: register quantised pixel and delayed markers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rgb_q <= '0;
      v_q   <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= bits_d;
      v_q   <= v_s1_q;
      ls_q  <= ls_s1_q;
      fs_q  <= fs_s1_q;
    end
  end

  assign rgb_111         = rgb_q;
  assign pix_valid_out   = v_q;
  assign line_start_out  = ls_q;
  assign frame_start_out = fs_q;

endmodule
